// File: rtl/segre_rf_restore.sv
// Architectural register file with history-file rollback: normal read/write with bypass,
// and a recovery mode that replays saved values from the history file while stalling.
module segre_rf_restore #(
  parameter int NUM_REGS  = 32,
  parameter int REG_SIZE  = 5,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic [REG_SIZE-1:0]  rs1_addr_i,
  output logic [WORD_SIZE-1:0] rs1_data_o,
  input  logic [REG_SIZE-1:0]  rs2_addr_i,
  output logic [WORD_SIZE-1:0] rs2_data_o,
  input  logic [REG_SIZE-1:0]  old_addr_i,
  output logic [WORD_SIZE-1:0] old_value_o,
  input  logic                 wb_we_i,
  input  logic [REG_SIZE-1:0]  wb_addr_i,
  input  logic [WORD_SIZE-1:0] wb_data_i,
  input  logic                 hf_recovering_i,
  input  logic                 hf_empty_i,
  input  logic [REG_SIZE-1:0]  hf_dest_reg_i,
  input  logic [WORD_SIZE-1:0] hf_value_i,
  output logic                 stall_o,
  output logic                 recovery_done_o,
  output logic [REG_SIZE:0]    restore_cnt_o,
  output logic                 wb_dropped_o
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_RECOVER = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e               state_q;
  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [REG_SIZE:0]    cnt_q;
  logic                 done_q;
  logic                 dropped_q;

  logic                 restore_take;
  logic                 restore_wr;
  logic                 wb_collide;
  logic                 wb_wr;
  logic                 wb_drop;
  logic                 bypass1;
  logic                 bypass2;
  logic [REG_SIZE:0]    cnt_inc;

  // The history file pops an entry every cycle it is recovering and non-empty, so the
  // entry presented in the NORMAL cycle that sees recovery start is consumed as well.
  always_comb begin
    restore_take = hf_recovering_i && !hf_empty_i && (state_q != ST_DONE);
    restore_wr   = restore_take && (hf_dest_reg_i != '0);
    wb_collide   = restore_wr && (hf_dest_reg_i == wb_addr_i);
    wb_wr        = (state_q == ST_NORMAL) && wb_we_i && (wb_addr_i != '0) && !wb_collide;
    wb_drop      = wb_we_i && ((state_q != ST_NORMAL) || wb_collide);
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    bypass1 = (state_q == ST_NORMAL) && wb_we_i && (wb_addr_i == rs1_addr_i);
    bypass2 = (state_q == ST_NORMAL) && wb_we_i && (wb_addr_i == rs2_addr_i);
    rs1_data_o  = '0;
    rs2_data_o  = '0;
    old_value_o = '0;
    if (rs1_addr_i != '0) rs1_data_o = bypass1 ? wb_data_i : regs_q[rs1_addr_i];
    if (rs2_addr_i != '0) rs2_data_o = bypass2 ? wb_data_i : regs_q[rs2_addr_i];
    // No bypass here: the history file must see the value before this cycle's write.
    if (old_addr_i != '0) old_value_o = regs_q[old_addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      state_q   <= ST_NORMAL;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dropped_q <= wb_drop;
      if (wb_wr)      regs_q[wb_addr_i]     <= wb_data_i;
      if (restore_wr) regs_q[hf_dest_reg_i] <= hf_value_i;
      case (state_q)
        ST_NORMAL: begin
          if (hf_recovering_i) begin
            state_q <= ST_RECOVER;
            cnt_q   <= restore_take ? {{REG_SIZE{1'b0}}, 1'b1} : '0;
          end
        end
        ST_RECOVER: begin
          if (restore_take) cnt_q <= cnt_inc;
          if (!hf_recovering_i || hf_empty_i) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (hf_recovering_i && !hf_empty_i) begin
            state_q <= ST_RECOVER;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_NORMAL;
          end
        end
        default: state_q <= ST_NORMAL;
      endcase
    end
  end

  assign stall_o         = (state_q != ST_NORMAL);
  assign recovery_done_o = done_q;
  assign restore_cnt_o   = cnt_q;
  assign wb_dropped_o    = dropped_q;

endmodule

// File: tb/tb_segre_rf_restore.sv
// Directed bench for segre_rf_restore: vector table for normal-mode reads/writes/bypass,
// hand-written sequences for recovery, reset abort, empty entry and counter saturation.
module tb_segre_rf_restore;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, old_addr_i, wb_addr_i, hf_dest_reg_i;
  logic [31:0] rs1_data_o, rs2_data_o, old_value_o, wb_data_i, hf_value_i;
  logic        wb_we_i, hf_recovering_i, hf_empty_i;
  logic        stall_o, recovery_done_o, wb_dropped_o;
  logic [5:0]  restore_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  ro;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] eo;
  } vec_t;

  vec_t vecs[10];

  segre_rf_restore dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .rs1_addr_i(rs1_addr_i), .rs1_data_o(rs1_data_o),
    .rs2_addr_i(rs2_addr_i), .rs2_data_o(rs2_data_o),
    .old_addr_i(old_addr_i), .old_value_o(old_value_o),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .hf_recovering_i(hf_recovering_i), .hf_empty_i(hf_empty_i),
    .hf_dest_reg_i(hf_dest_reg_i), .hf_value_i(hf_value_i),
    .stall_o(stall_o), .recovery_done_o(recovery_done_o),
    .restore_cnt_o(restore_cnt_o), .wb_dropped_o(wb_dropped_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; old_addr_i = '0;
    hf_recovering_i = 1'b0; hf_empty_i = 1'b0; hf_dest_reg_i = '0; hf_value_i = '0;
  endtask

  task automatic do_reset();
    rsn_i = 1'b1;
    tick(); tick();
    rsn_i = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a, input logic [31:0] exp, input string name);
    rs1_addr_i = a; rs2_addr_i = a;
    #1;
    check({name, "_rs1"}, rs1_data_o, exp);
    check({name, "_rs2"}, rs2_data_o, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1; wb_addr_i = a; wb_data_i = d;
    tick();
    wb_we_i = 1'b0;
  endtask

  int stall_cycles, done_cycles, drop_cycles;

  task automatic count_outputs();
    if (stall_o) stall_cycles++;
    if (recovery_done_o) done_cycles++;
    if (wb_dropped_o) drop_cycles++;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h1,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0};
    vecs[4] = '{1'b1, 5'd3,  32'h11,       5'd3,  5'd4,  5'd3,  32'h11,       32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd4,  32'h22,       5'd3,  5'd4,  5'd4,  32'h11,       32'h22,       32'h0};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  5'd31, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
    vecs[7] = '{1'b1, 5'd5,  32'h12345678, 5'd4,  5'd5,  5'd5,  32'h22,       32'h12345678, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 5'd0,  32'h12345678, 32'hFFFFFFFF, 32'h0};
    vecs[9] = '{1'b1, 5'd7,  32'h77,       5'd7,  5'd1,  5'd7,  32'h77,       32'h0,        32'h0};

    idle();
    do_reset();
    #1;
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    check("reset_done", {31'b0, recovery_done_o}, 32'h0);
    check("reset_dropped", {31'b0, wb_dropped_o}, 32'h0);
    check("reset_cnt", {26'b0, restore_cnt_o}, 32'h0);
    for (int i = 0; i < 32; i++) read_pair(i[4:0], 32'h0, "reset_read");

    // Normal mode vector table
    for (int i = 0; i < 10; i++) begin
      wb_we_i = vecs[i].we; wb_addr_i = vecs[i].wa; wb_data_i = vecs[i].wd;
      rs1_addr_i = vecs[i].r1; rs2_addr_i = vecs[i].r2; old_addr_i = vecs[i].ro;
      #1;
      check($sformatf("vec%0d_rs1", i), rs1_data_o, vecs[i].e1);
      check($sformatf("vec%0d_rs2", i), rs2_data_o, vecs[i].e2);
      check($sformatf("vec%0d_old", i), old_value_o, vecs[i].eo);
      check($sformatf("vec%0d_stall", i), {31'b0, stall_o}, 32'h0);
      tick();
      check($sformatf("vec%0d_dropped", i), {31'b0, wb_dropped_o}, 32'h0);
    end
    idle();

    // Recovery: stream (x3,A),(x4,B),(x3,C), wb to x7 dropped during RECOVER
    stall_cycles = 0; done_cycles = 0; drop_cycles = 0;
    hf_recovering_i = 1'b1; hf_dest_reg_i = 5'd3; hf_value_i = 32'hA;
    #1; count_outputs();
    check("rec_a_stall", {31'b0, stall_o}, 32'h0);
    tick();
    hf_dest_reg_i = 5'd4; hf_value_i = 32'hB;
    wb_we_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h55;
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd7;
    #1; count_outputs();
    check("rec_b_x3", rs1_data_o, 32'hA);
    check("rec_b_no_bypass_x7", rs2_data_o, 32'h77);
    check("rec_b_cnt", {26'b0, restore_cnt_o}, 32'd1);
    tick();
    wb_we_i = 1'b0;
    hf_dest_reg_i = 5'd3; hf_value_i = 32'hC;
    #1; count_outputs();
    check("rec_c_dropped", {31'b0, wb_dropped_o}, 32'h1);
    check("rec_c_cnt", {26'b0, restore_cnt_o}, 32'd2);
    tick();
    hf_recovering_i = 1'b0; hf_empty_i = 1'b1;
    #1; count_outputs();
    check("rec_d_cnt", {26'b0, restore_cnt_o}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      count_outputs();
    end
    check("rec_stall_cycles", stall_cycles, 32'd4);
    check("rec_done_cycles", done_cycles, 32'd1);
    check("rec_drop_cycles", drop_cycles, 32'd1);
    check("rec_cnt_hold", {26'b0, restore_cnt_o}, 32'd3);
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd4; old_addr_i = 5'd7;
    #1;
    check("rec_x3", rs1_data_o, 32'hC);
    check("rec_x4", rs2_data_o, 32'hB);
    check("rec_x7", old_value_o, 32'h77);
    idle();

    // Reset asserted on the second restore cycle aborts recovery
    hf_recovering_i = 1'b1; hf_dest_reg_i = 5'd3; hf_value_i = 32'h99;
    tick();
    hf_dest_reg_i = 5'd4; hf_value_i = 32'h98;
    rsn_i = 1'b1;
    tick();
    rsn_i = 1'b0;
    hf_recovering_i = 1'b0; hf_empty_i = 1'b1;
    done_cycles = 0;
    #1;
    check("abort_stall", {31'b0, stall_o}, 32'h0);
    check("abort_cnt", {26'b0, restore_cnt_o}, 32'h0);
    read_pair(5'd3, 32'h0, "abort_x3");
    read_pair(5'd5, 32'h0, "abort_x5");
    read_pair(5'd31, 32'h0, "abort_x31");
    for (int i = 0; i < 3; i++) begin
      count_outputs();
      tick();
    end
    check("abort_no_done", done_cycles, 32'd0);
    idle();

    // Recovery starting with an empty history file
    write_reg(5'd9, 32'h42);
    hf_recovering_i = 1'b1; hf_empty_i = 1'b1; hf_dest_reg_i = 5'd9; hf_value_i = 32'h5A;
    tick();
    check("empty_stall", {31'b0, stall_o}, 32'h1);
    check("empty_cnt", {26'b0, restore_cnt_o}, 32'h0);
    tick();
    check("empty_done", {31'b0, recovery_done_o}, 32'h1);
    tick();
    check("empty_back_normal", {31'b0, stall_o}, 32'h0);
    check("empty_done_clear", {31'b0, recovery_done_o}, 32'h0);
    check("empty_cnt_final", {26'b0, restore_cnt_o}, 32'h0);
    read_pair(5'd9, 32'h42, "empty_x9");
    idle();

    // Counter saturation with a long stream of dest-0 entries
    hf_recovering_i = 1'b1; hf_dest_reg_i = 5'd0; hf_value_i = 32'hBAD;
    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt10", {26'b0, restore_cnt_o}, 32'd10);
    for (int i = 0; i < 60; i++) tick();
    check("sat_cnt_max", {26'b0, restore_cnt_o}, 32'd63);
    read_pair(5'd0, 32'h0, "sat_x0");
    hf_recovering_i = 1'b0;
    tick(); tick();
    check("sat_normal", {31'b0, stall_o}, 32'h0);
    check("sat_cnt_hold", {26'b0, restore_cnt_o}, 32'd63);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
